// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Brief    : Shares the single mem_ctrl line-transaction port between several
//            DMA-style requesters. Grants one requester at a time at
//            cache-line granularity, optionally holds the grant across a
//            locked burst (capped at MAX_BURST lines), and routes tx_done,
//            rd_valid and read data back to the current owner only.
//            Optional build macro MEM_ARB_FIXED_PRIO_EN: when defined the
//            lowest-index pending requester always wins; when undefined
//            arbitration is round-robin starting at rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
  input  logic [512*NUM_REQ-1:0]        req_wdata,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            req_tx_done,
  output logic [NUM_REQ-1:0]            req_rd_valid,
  output logic [511:0]                  req_rdata,
  output logic [1:0]                    op,
  output logic [ADDR_WIDTH-1:0]         raw_address,
  output logic [511:0]                  common_data_bus_read_in,
  input  logic [511:0]                  common_data_bus_write_out,
  input  logic                          tx_done,
  input  logic                          rd_valid
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state,    w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant,    w_grant_nxt;
  logic [c_IDX_W-1:0]    r_owner,    w_owner_nxt;
  logic [7:0]            r_beat_cnt, w_beat_nxt;
  logic [NUM_REQ-1:0]    w_pending;
  logic                  w_found;
  logic [c_IDX_W-1:0]    w_win;
  logic                  w_release;
  logic [1:0]            w_op_arr    [NUM_REQ];
  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [511:0]          w_wdata_arr [NUM_REQ];
  logic [1:0]            w_own_op;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [c_IDX_W-1:0]    r_rr_ptr, w_rr_nxt;
  logic [c_IDX_W-1:0]    w_idx;
`endif

  // Unpack the flat per-requester buses; op 01/11 is a request, 10 is
  // reserved and reads as idle, so bit 0 alone marks a pending request.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign w_op_arr[i]    = req_op[2*i +: 2];
    assign w_addr_arr[i]  = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
    assign w_wdata_arr[i] = req_wdata[512*i +: 512];
    assign w_pending[i]   = req_op[2*i];
  end

  assign w_own_op  = w_op_arr[r_owner];
  assign req_grant = r_grant;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Winner select: lowest-index pending requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_pending[k]) begin
        w_found = 1'b1;
        w_win   = c_IDX_W'(k);
      end
    end
  end
`else
  // Winner select: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
`endif

  // Next state: grant from IDLE, then in BUSY either extend a locked burst,
  // release on the final line, or release on owner abort.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat_cnt;
    w_release   = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    w_rr_nxt    = r_rr_ptr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = w_win;
          w_grant_nxt = NUM_REQ'(1) << w_win;
          w_beat_nxt  = '0;
        end
      end
      ST_BUSY: begin
        if (tx_done) begin
          // beat_cnt+1 is the number of lines completed including this one.
          if (req_lock[r_owner] && (({1'b0, r_beat_cnt} + 9'd1) < 9'(MAX_BURST))) begin
            w_beat_nxt = r_beat_cnt + 8'd1;
          end else begin
            w_release = 1'b1;
          end
        end else if (!w_own_op[0]) begin
          w_release = 1'b1;
        end
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_beat_nxt  = '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          w_rr_nxt    = c_IDX_W'((int'(r_owner) + 1) % NUM_REQ);
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_beat_nxt  = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_nxt;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_rr_ptr   <= w_rr_nxt;
`endif
    end
  end

  // Port muxing: forward the owner's request to mem_ctrl and route the
  // completion strobes back to it; everything is quiet while IDLE.
  always_comb begin
    op                      = 2'b00;
    raw_address             = '0;
    common_data_bus_read_in = '0;
    req_tx_done             = '0;
    req_rd_valid            = '0;
    req_rdata               = '0;
    if (r_state == ST_BUSY) begin
      op                      = w_own_op;
      raw_address             = w_addr_arr[r_owner];
      common_data_bus_read_in = w_wdata_arr[r_owner];
      if (tx_done) begin
        req_tx_done = r_grant;
      end
      if (rd_valid) begin
        req_rd_valid = r_grant;
        req_rdata    = common_data_bus_write_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Brief    : Randomized bench for mem_req_arbiter. Requester agents and a
//            mem_ctrl responder are driven from a transaction-level model
//            that predicts grants and line completions; a separate monitor
//            compares DUT outputs against the queued predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

  localparam int NUM_REQ = 3;
  localparam int AW      = 32;
  localparam int MB      = 4;
  localparam int N_CYC   = 3000;
  localparam int RST_AT  = 1500;
  localparam int PHASE2  = 600;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [2*NUM_REQ-1:0]   req_op;
  logic [AW*NUM_REQ-1:0]  req_addr;
  logic [512*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]     req_lock;
  logic [NUM_REQ-1:0]     req_grant, req_tx_done, req_rd_valid;
  logic [511:0]           req_rdata;
  logic [1:0]             op;
  logic [AW-1:0]          raw_address;
  logic [511:0]           common_data_bus_read_in;
  logic [511:0]           common_data_bus_write_out;
  logic                   tx_done, rd_valid;

  mem_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .req_op                    (req_op),
    .req_addr                  (req_addr),
    .req_wdata                 (req_wdata),
    .req_lock                  (req_lock),
    .req_grant                 (req_grant),
    .req_tx_done               (req_tx_done),
    .req_rd_valid              (req_rd_valid),
    .req_rdata                 (req_rdata),
    .op                        (op),
    .raw_address               (raw_address),
    .common_data_bus_read_in   (common_data_bus_read_in),
    .common_data_bus_write_out (common_data_bus_write_out),
    .tx_done                   (tx_done),
    .rd_valid                  (rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic [NUM_REQ-1:0] grant;
  } gev_t;

  typedef struct {
    int           cyc;
    int           idx;
    bit           rd;
    logic [511:0] rdata;
    logic [1:0]   op;
    logic [AW-1:0] addr;
    logic [511:0] wdata;
  } cev_t;

  gev_t gq[$];
  cev_t cq[$];

  // Requester agents: a request is a run of a_left lines starting at a_addr.
  bit            a_act  [NUM_REQ];
  bit            a_wr   [NUM_REQ];
  logic [AW-1:0] a_addr [NUM_REQ];
  logic [511:0]  a_wdata[NUM_REQ];
  int            a_left [NUM_REQ];

  // Reference model of who owns the port.
  int                 m_owner;
  int                 m_lines;
  int                 m_rr;
  int                 mem_wait;
  logic [NUM_REQ-1:0] m_grant;
  bit                 did_rst;

  int  cyc      = 0;
  bit  done     = 1'b0;
  int  checks   = 0;
  int  failures = 0;

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Arbitration rule: scan from the start index, wrapping; fixed-priority
  // builds always scan from index 0.
  function automatic int pick(input logic [NUM_REQ-1:0] p, input int start);
    int s;
    s = start;
`ifdef MEM_ARB_FIXED_PRIO_EN
    s = 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (p[(s + k) % NUM_REQ]) return (s + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic spawn(input int i, input int c);
    a_act[i]   = 1'b1;
    a_wr[i]    = (c < PHASE2) ? 1'b1 : 1'($urandom_range(1, 0));
    a_addr[i]  = $urandom;
    a_wdata[i] = rand512();
    a_left[i]  = (c < PHASE2) ? 1 : 1 + int'($urandom_range(5, 0));
  endtask

  // One bus cycle: agents, mem_ctrl responder, then the model advances.
  task automatic step(input int c);
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] new_grant;
    bit rst_now, allow_new, lock_now;
    int g, w;
    cev_t ce;
    allow_new = (c <= N_CYC);
    rst_now   = (c <= 3) || (c >= RST_AT && !did_rst && m_owner >= 0);
    if (c > 3 && rst_now) did_rst = 1'b1;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (!a_act[i] && allow_new &&
          (c < PHASE2 || (rst_now && c > 3) || $urandom_range(2, 0) == 0))
        spawn(i, c);
    end
    if (!rst_now && allow_new && c >= PHASE2 && m_owner >= 0 && mem_wait > 0 &&
        $urandom_range(11, 0) == 0)
      a_act[m_owner] = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[2*i +: 2]      = a_act[i] ? (a_wr[i] ? 2'b11 : 2'b01)
                                       : ($urandom_range(1, 0) == 1 ? 2'b10 : 2'b00);
      req_addr[AW*i +: AW]  = a_act[i] ? a_addr[i] : $urandom;
      req_wdata[512*i +: 512] = a_act[i] ? a_wdata[i] : rand512();
      req_lock[i]           = a_act[i] && (a_left[i] > 1);
    end
    rst_n = !rst_now;

    tx_done  = 1'b0;
    rd_valid = 1'b0;
    common_data_bus_write_out = rand512();
    if (!rst_now) begin
      if (m_owner >= 0) begin
        if (a_act[m_owner]) begin
          if (mem_wait == 0) begin
            tx_done  = 1'b1;
            rd_valid = !a_wr[m_owner];
            ce.cyc   = c;
            ce.idx   = m_owner;
            ce.rd    = !a_wr[m_owner];
            ce.rdata = common_data_bus_write_out;
            ce.op    = a_wr[m_owner] ? 2'b11 : 2'b01;
            ce.addr  = a_addr[m_owner];
            ce.wdata = a_wdata[m_owner];
            cq.push_back(ce);
          end else begin
            mem_wait--;
          end
        end
      end else begin
        tx_done  = ($urandom_range(5, 0) == 0);
        rd_valid = ($urandom_range(5, 0) == 0);
      end
    end

    if (rst_now) begin
      m_owner  = -1;
      m_lines  = 0;
      m_rr     = 0;
      mem_wait = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < NUM_REQ; i++) pend[i] = a_act[i];
      w = pick(pend, m_rr);
      if (w >= 0) begin
        m_owner  = w;
        m_lines  = 0;
        mem_wait = int'($urandom_range(3, 0));
      end
    end else begin
      g = m_owner;
      if (tx_done) begin
        lock_now = req_lock[g];
        a_left[g]--;
        if (a_left[g] == 0) begin
          a_act[g] = 1'b0;
        end else begin
          a_addr[g]  = a_addr[g] + 1;
          a_wdata[g] = rand512();
        end
        if (lock_now && (m_lines + 1 < MB)) begin
          m_lines++;
          mem_wait = int'($urandom_range(3, 0));
        end else begin
          m_owner = -1;
          m_lines = 0;
          m_rr    = (g + 1) % NUM_REQ;
        end
      end else if (!a_act[g]) begin
        m_owner = -1;
        m_lines = 0;
        m_rr    = (g + 1) % NUM_REQ;
      end
    end

    new_grant = (m_owner < 0) ? '0 : onehot(m_owner);
    if (new_grant != m_grant) begin
      gq.push_back('{cyc: c + 1, grant: new_grant});
      m_grant = new_grant;
    end
  endtask

  // Driver: stimulus and model, one step per clock.
  initial begin
    rst_n = 1'b0;
    req_op = '0; req_addr = '0; req_wdata = '0; req_lock = '0;
    common_data_bus_write_out = '0; tx_done = 1'b0; rd_valid = 1'b0;
    m_owner = -1; m_lines = 0; m_rr = 0; mem_wait = 0; m_grant = '0; did_rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_act[i] = 1'b0; a_wr[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0; a_left[i] = 0;
    end
    for (int c = 1; c <= N_CYC + 100; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      step(c);
    end
    @(posedge clk);
    #1;
    done = 1'b1;
  end

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops predictions whenever the DUT changes grant or routes a
  // completion, and checks idle/gating behaviour every cycle.
  initial begin
    logic [NUM_REQ-1:0] mon_grant;
    gev_t ge;
    cev_t ce;
    mon_grant = '0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (req_grant !== mon_grant) begin
        if (gq.size() == 0) begin
          check("grant_unexpected", 512'(req_grant), 512'(mon_grant));
        end else begin
          ge = gq.pop_front();
          check("grant", 512'(req_grant), 512'(ge.grant));
          check("grant_cycle", 512'(cyc), 512'(ge.cyc));
        end
        mon_grant = req_grant;
      end
      if ((req_tx_done | req_rd_valid) != '0) begin
        if (cq.size() == 0) begin
          check("route_unexpected", 512'({req_tx_done, req_rd_valid}), 512'(0));
        end else begin
          ce = cq.pop_front();
          check("tx_done_route", 512'(req_tx_done), 512'(onehot(ce.idx)));
          check("rd_valid_route", 512'(req_rd_valid), ce.rd ? 512'(onehot(ce.idx)) : 512'(0));
          if (ce.rd) check("rdata", req_rdata, ce.rdata);
          check("done_op", 512'(op), 512'(ce.op));
          check("done_addr", 512'(raw_address), 512'(ce.addr));
          check("done_wdata", common_data_bus_read_in, ce.wdata);
          check("done_cycle", 512'(cyc), 512'(ce.cyc));
        end
      end
      if (req_rd_valid == '0) check("rdata_gated", req_rdata, 512'(0));
      if (req_grant == '0) begin
        check("idle_op", 512'(op), 512'(0));
        check("idle_addr", 512'(raw_address), 512'(0));
        check("idle_wdata", common_data_bus_read_in, 512'(0));
      end
    end
    check("grant_events_missing", 512'(gq.size()), 512'(0));
    check("completions_missing", 512'(cq.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
